fir_sample_feeder: RTL and testbench
====================================

Name: fir_sample_feeder

Overview:
- Stream-side partner of the folded 8-tap FIR controller. It buffers upstream samples and drives the filter's en/sample inputs only while the filter signals ready.
- It collects each filter result on the filter's valid pulse and presents it downstream on a valid/ready handshake.
- It uses a credit count so no result is ever dropped. It sits between the sample source and the FIR datapath/fsm pair.

Parameters:
DATA_W, 16, sample width on s_data and f_x
Y_W, 36, filter result width on f_y and m_data
IN_DEPTH, 4, input FIFO entries; power of two, at least 2
OUT_DEPTH, 2, output buffer entries; also the credit limit
CAPTURE_DLY, 1, cycles after f_valid at which f_y is sampled; legal values 0 or 1

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
s_data  in  DATA_W  upstream sample
s_valid  in  1  upstream sample valid
s_ready  out  1  FIFO can accept a sample (not full)
f_ready  in  1  filter can take a sample this cycle
f_en  out  1  issue sample to filter
f_x  out  DATA_W  sample presented with f_en (FIFO head)
f_valid  in  1  filter result-complete pulse
f_y  in  Y_W  filter accumulator output
m_data  out  Y_W  result to downstream
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts
in_level  out  clog2(IN_DEPTH)+1  input FIFO occupancy
err_spurious  out  1  sticky: f_valid arrived with no outstanding issue

Behaviour:
- Reset (rst low at edge): FIFOs empty, outstanding=0, pending capture cleared, err_spurious=0, m_valid=0. While rst is low, s_ready=0 and f_en=0. All other outputs are 0 after reset.
- Input push: when s_valid && s_ready, write s_data at the tail. s_ready = rst && (in_level < IN_DEPTH).
- Credit: credits_used = outstanding + out_count. The issue condition is ok_issue = in_level>0 && credits_used < OUT_DEPTH.
- Issue:
  - f_en = rst && f_ready && ok_issue (combinational); f_x = FIFO head.
  - f_en is never high without f_ready. On f_en the head pops and outstanding increments at that edge.
- Simultaneous push and pop: both take effect; in_level unchanged. A push into a full FIFO is impossible because s_ready is low. A push into an empty FIFO is not issuable until the next cycle (no bypass).
- Capture:
  - CAPTURE_DLY=0: f_y is written into the output buffer at the same edge as f_valid.
  - CAPTURE_DLY=1: a pending flag is set at that edge, and f_y is written one cycle later.
  - Each capture decrements outstanding. A result capture is guaranteed buffer space by the credit rule.
- Spurious valid: f_valid while outstanding=0 (including pending-adjusted count) sets err_spurious. Nothing is captured and outstanding stays 0.
- Simultaneous issue and capture: outstanding is unchanged.
- Output: 2-entry-style FIFO of OUT_DEPTH. m_valid = out_count>0; m_data = head. A pop on m_valid && m_ready. Capture and pop in the same cycle are both honoured.
- Occupancy is held as wrap-around pointers with an extra MSB. full = (ptr_msb differ && lower bits equal); empty = pointers equal.
- Reset mid-operation: all state is discarded, including pending capture and buffered results. A f_valid arriving in the cycle after reset release is treated as spurious.
- Latency: sample accepted at edge t is issuable at t+1 at the earliest. Result-to-m_valid is CAPTURE_DLY+1 cycles after f_valid.

Test Plan:
- Reset then idle: rst low 2 cycles -> s_ready=0, f_en=0, m_valid=0; after release s_ready=1, in_level=0.
- Single sample 0x0005 with f_ready held 1, model f_valid 3 cycles after f_en and f_y=36'h123 (DLY=1) -> f_en pulses once with f_x=0x0005; m_valid rises 2 cycles after f_valid with m_data=0x123.
- Fill FIFO with 4 samples, f_ready=0 -> s_ready=0 at in_level=4. A 5th s_valid is held off. Raise f_ready -> samples issue in order 1,2,3,4.
- m_ready=0, 4 queued samples, filter always ready -> exactly 2 f_en pulses, then f_en stays 0. Assert m_ready -> issues resume and all 4 results arrive in order, none lost.
- f_valid pulse with no prior issue -> err_spurious=1 and stays 1 until reset; m_valid stays 0.
- rst asserted 1 cycle after an issue, before f_valid -> after release outstanding=0. The late f_valid sets err_spurious, and no m_valid appears.

Source files
------------

// File: rtl/fir_sample_feeder.sv
// Stream adapter between the sample source and the folded FIR pair. It buffers
// samples, issues them while the filter is ready, and queues results with credit control.
module fir_sample_feeder #(
   parameter int DATA_W      = 16,
   parameter int Y_W         = 36,
   parameter int IN_DEPTH    = 4,
   parameter int OUT_DEPTH   = 2,
   parameter int CAPTURE_DLY = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_W-1:0]           s_data,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic                        f_ready,
   output logic                        f_en,
   output logic [DATA_W-1:0]           f_x,
   input  logic                        f_valid,
   input  logic [Y_W-1:0]              f_y,
   output logic [Y_W-1:0]              m_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [$clog2(IN_DEPTH):0]   in_level,
   output logic                        err_spurious
);

   localparam int AW = $clog2(IN_DEPTH);
   localparam int OW = $clog2(OUT_DEPTH);
   localparam int CW = OW + 1;

   logic [DATA_W-1:0] in_mem [IN_DEPTH];
   logic [AW:0]       in_wp, in_rp;
   logic [Y_W-1:0]    out_mem [OUT_DEPTH];
   logic [OW:0]       out_wp, out_rp;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     out_count;
   logic [CW:0]       credits_used;
   logic              pending;
   logic              pending_adj;
   logic              in_full, in_empty, out_empty;
   logic              ok_issue, push, pop_out, spur, accept_valid, capture;

   assign in_level  = in_wp - in_rp;
   assign in_empty  = (in_wp == in_rp);
   assign in_full   = (in_wp[AW] != in_rp[AW]) && (in_wp[AW-1:0] == in_rp[AW-1:0]);
   assign out_count = out_wp - out_rp;
   assign out_empty = (out_wp == out_rp);

   // Results in flight plus results parked downstream may never exceed the buffer.
   assign credits_used = {1'b0, outstanding} + {1'b0, out_count};
   assign ok_issue     = !in_empty && (credits_used < (CW+1)'(OUT_DEPTH));

   assign s_ready = rst && !in_full;
   assign f_en    = rst && f_ready && ok_issue;
   assign f_x     = in_mem[in_rp[AW-1:0]];
   assign push    = s_valid && s_ready;

   // A pending capture has already consumed its issue, so discount it here.
   assign pending_adj  = (CAPTURE_DLY != 0) && pending;
   assign spur         = f_valid && (outstanding == CW'(pending_adj));
   assign accept_valid = f_valid && !spur;
   assign capture      = (CAPTURE_DLY != 0) ? pending : accept_valid;

   assign m_valid = !out_empty;
   assign m_data  = out_mem[out_rp[OW-1:0]];
   assign pop_out = m_valid && m_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         in_wp        <= '0;
         in_rp        <= '0;
         out_wp       <= '0;
         out_rp       <= '0;
         outstanding  <= '0;
         pending      <= 1'b0;
         err_spurious <= 1'b0;
         for (int i = 0; i < IN_DEPTH; i++) in_mem[i] <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) out_mem[i] <= '0;
      end else begin
         if (push) begin
            in_mem[in_wp[AW-1:0]] <= s_data;
            in_wp                 <= in_wp + 1'b1;
         end
         if (f_en) in_rp <= in_rp + 1'b1;
         if (capture) begin
            out_mem[out_wp[OW-1:0]] <= f_y;
            out_wp                  <= out_wp + 1'b1;
         end
         if (pop_out) out_rp <= out_rp + 1'b1;
         case ({f_en, capture})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         pending <= (CAPTURE_DLY != 0) && accept_valid;
         if (spur) err_spurious <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: queue-level reference model with a per-cycle
// compare, a reactive filter stand-in, and directed scenarios with literal checks.
module tb_fir_sample_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        f_ready;
   logic        f_en;
   logic [15:0] f_x;
   logic        f_valid;
   logic [35:0] f_y;
   logic [35:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic [2:0]  in_level;
   logic        err_spurious;

   fir_sample_feeder dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .f_ready(f_ready), .f_en(f_en), .f_x(f_x), .f_valid(f_valid), .f_y(f_y),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .in_level(in_level),
      .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Filter stand-in: result = sample + 0x11E, three cycles after issue,
   // never two results in adjacent cycles so f_y holds through the capture cycle.
   int          cyc = 0;
   int          due_q[$];
   logic [35:0] ydue_q[$];
   int          last_v = -10;
   int          fv_cyc = 0;

   function automatic void sched(input int earliest, input logic [35:0] y);
      int v;
      v = (earliest > last_v + 2) ? earliest : last_v + 2;
      last_v = v;
      due_q.push_back(v);
      ydue_q.push_back(y);
   endfunction

   initial begin
      f_valid = 1'b0;
      f_y     = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            f_valid = 1'b1;
            f_y     = ydue_q[0];
            due_q.delete(0);
            ydue_q.delete(0);
            fv_cyc  = cyc;
         end else begin
            f_valid = 1'b0;
         end
      end
   end

   // Observation of what the DUT actually did (feeds the filter stand-in and literal checks)
   int          fen_count = 0;
   int          mv_count = 0;
   int          mv_rise_cyc = 0;
   logic        mv_prev = 1'b0;
   logic [15:0] iss_q[$];
   logic [35:0] got_q[$];

   always @(negedge clk) begin
      if (f_en) begin
         fen_count++;
         iss_q.push_back(f_x);
         sched(cyc + 3, {20'h0, f_x} + 36'h11E);
      end
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (m_valid) mv_count++;
      if (m_valid && !mv_prev) mv_rise_cyc = cyc;
      mv_prev = m_valid;
   end

   // Reference model: sample queue, result queue, results owed by the filter.
   logic [15:0] mq_in[$];
   logic [35:0] mq_out[$];
   int          m_owed = 0;
   bit          m_pend = 0;
   bit          m_err = 0;
   bit          started = 0;

   function automatic bit exp_fen();
      return rst && f_ready && (mq_in.size() > 0) && (m_owed + mq_out.size() < 2);
   endfunction

   always @(posedge clk) begin
      bit fen, spur, cap, mpop, spush;
      if (!rst) begin
         mq_in.delete();
         mq_out.delete();
         m_owed  = 0;
         m_pend  = 0;
         m_err   = 0;
         started = 1;
      end else if (started) begin
         fen   = exp_fen();
         spur  = f_valid && (m_owed - int'(m_pend) == 0);
         cap   = m_pend;
         mpop  = (mq_out.size() > 0) && m_ready;
         spush = s_valid && (mq_in.size() < 4);
         if (mpop) mq_out.delete(0);
         if (cap) mq_out.push_back(f_y);
         if (fen) mq_in.delete(0);
         if (spush) mq_in.push_back(s_data);
         m_owed = m_owed + int'(fen) - int'(cap);
         m_pend = f_valid && !spur;
         if (spur) m_err = 1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("s_ready", s_ready, rst && (mq_in.size() < 4));
         chk("in_level", in_level, mq_in.size());
         chk("f_en", f_en, exp_fen());
         if (mq_in.size() > 0) chk("f_x", f_x, mq_in[0]);
         chk("m_valid", m_valid, mq_out.size() > 0);
         if (mq_out.size() > 0) chk("m_data", m_data, mq_out[0]);
         chk("err_spurious", err_spurious, m_err);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push_sample(input logic [15:0] d);
      s_valid = 1'b1;
      s_data  = d;
      tick();
   endtask

   task automatic wait_got(input int want, input int limit, input string name);
      int n = 0;
      while (got_q.size() < want && n < limit) begin
         tick();
         n++;
      end
      chk(name, got_q.size() >= want, 1'b1);
   endtask

   function automatic logic [35:0] got_at(input int i);
      return (got_q.size() > i) ? got_q[i] : '1;
   endfunction

   function automatic logic [15:0] iss_at(input int i);
      return (iss_q.size() > i) ? iss_q[i] : '1;
   endfunction

   initial begin
      rst = 1'b0; s_valid = 1'b0; s_data = '0; f_ready = 1'b0; m_ready = 1'b0;

      // Reset then idle
      idle(2);
      @(negedge clk);
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_f_en", f_en, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rel_s_ready", s_ready, 1'b1);
      chk("rel_in_level", in_level, 3'd0);

      // Single sample through the filter
      tick();
      f_ready = 1'b1; m_ready = 1'b1;
      got_q.delete(); iss_q.delete(); fen_count = 0;
      push_sample(16'h0005);
      s_valid = 1'b0;
      wait_got(1, 20, "single_timeout");
      chk("single_fen_count", fen_count, 1);
      chk("single_f_x", iss_at(0), 16'h0005);
      chk("single_m_data", got_at(0), 36'h123);
      chk("single_latency", mv_rise_cyc - fv_cyc, 2);
      idle(6);

      // Fill FIFO with filter stalled, then drain in order
      f_ready = 1'b0;
      got_q.delete();
      for (int i = 1; i <= 4; i++) push_sample(16'(i));
      s_data = 16'h0005;
      @(negedge clk);
      chk("full_s_ready", s_ready, 1'b0);
      chk("full_in_level", in_level, 3'd4);
      idle(2);
      s_valid = 1'b0;
      iss_q.delete();
      f_ready = 1'b1;
      wait_got(4, 40, "fill_timeout");
      for (int i = 0; i < 4; i++) chk("fill_order", iss_at(i), 16'(i + 1));
      chk("fill_no_fifth", iss_q.size(), 4);
      idle(6);

      // Credit limit with downstream stalled
      f_ready = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_sample(16'h000A + 16'(i));
      s_valid = 1'b0;
      fen_count = 0; got_q.delete();
      f_ready = 1'b1;
      idle(12);
      @(negedge clk);
      chk("credit_fen_count", fen_count, 2);
      chk("credit_in_level", in_level, 3'd2);
      chk("credit_m_valid", m_valid, 1'b1);
      tick();
      m_ready = 1'b1;
      wait_got(4, 60, "credit_timeout");
      for (int i = 0; i < 4; i++) chk("credit_result", got_at(i), 36'h128 + 36'(i));
      chk("credit_fen_total", fen_count, 4);
      idle(8);

      // Spurious result pulse
      mv_count = 0;
      sched(cyc + 1, 36'hABC);
      idle(3);
      @(negedge clk);
      chk("spur_err", err_spurious, 1'b1);
      chk("spur_m_valid", m_valid, 1'b0);
      idle(5);
      @(negedge clk);
      chk("spur_sticky", err_spurious, 1'b1);
      chk("spur_no_output", mv_count, 0);

      // Reset between issue and result
      tick();
      fen_count = 0; got_q.delete();
      push_sample(16'h0007);
      s_valid = 1'b0;
      begin
         int n = 0;
         while (fen_count < 1 && n < 10) begin
            tick();
            n++;
         end
         chk("midrst_issue_timeout", fen_count >= 1, 1'b1);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      mv_count = 0;
      @(negedge clk);
      chk("midrst_err_cleared", err_spurious, 1'b0);
      idle(8);
      @(negedge clk);
      chk("midrst_late_spur", err_spurious, 1'b1);
      chk("midrst_no_m_valid", mv_count, 0);
      chk("midrst_no_result", got_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
